// File: rtl/bsc_axiu_stream_dest_router.sv
// Steers whole AXI-Stream packets to one of NUM_OUT outputs by first-beat tdest.
// Packets with an out-of-range destination are swallowed and counted.
module bsc_axiu_stream_dest_router #(
    parameter int TID_WIDTH = 4,
    parameter int NUM_OUT   = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [63:0]          inStream_tdata,
    input  logic [2:0]           inStream_tdest,
    input  logic [TID_WIDTH-1:0] inStream_tid,
    input  logic                 inStream_tlast,
    input  logic                 inStream_tvalid,
    output logic                 inStream_tready,
    output logic [63:0]          outStream_tdata,
    output logic [2:0]           outStream_tdest,
    output logic [TID_WIDTH-1:0] outStream_tid,
    output logic                 outStream_tlast,
    output logic [NUM_OUT-1:0]   outStream_tvalid,
    input  logic [NUM_OUT-1:0]   outStream_tready,
    output logic [15:0]          drop_count,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [3:0] LP_NUM_OUT = 4'(NUM_OUT);

    logic [1:0]           r_state;
    logic                 r_hold_vld;
    logic [2:0]           r_sel;
    logic [63:0]          r_tdata;
    logic [2:0]           r_tdest;
    logic [TID_WIDTH-1:0] r_tid;
    logic                 r_tlast;
    logic [15:0]          r_drop_count;

    logic w_first;
    logic w_dest_bad;
    logic w_drop_beat;
    logic w_port_rdy;
    logic w_acc;
    logic w_load;
    logic w_new_drop;

    assign w_first     = (r_state == S_IDLE);
    assign w_dest_bad  = ({1'b0, inStream_tdest} >= LP_NUM_OUT);
    // Discarded beats never touch the hold register, so they are always accepted.
    assign w_drop_beat = (r_state == S_DROP) || (w_first && inStream_tvalid && w_dest_bad);

    always_comb begin
        w_port_rdy = 1'b0;
        for (int p = 0; p < NUM_OUT; p++) begin
            if (r_sel == 3'(p)) w_port_rdy = outStream_tready[p];
        end
    end

    // Ready follows downstream combinationally so drain and load share one cycle.
    assign inStream_tready = w_drop_beat || !r_hold_vld || w_port_rdy;
    assign w_acc           = inStream_tvalid && inStream_tready;
    assign w_load          = w_acc && !w_drop_beat;
    assign w_new_drop      = w_acc && w_first && w_dest_bad;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_hold_vld   <= 1'b0;
            r_sel        <= 3'd0;
            r_tdata      <= 64'd0;
            r_tdest      <= 3'd0;
            r_tid        <= '0;
            r_tlast      <= 1'b0;
            r_drop_count <= 16'd0;
        end else begin
            if (w_load) begin
                r_hold_vld <= 1'b1;
                r_tdata    <= inStream_tdata;
                r_tdest    <= inStream_tdest;
                r_tid      <= inStream_tid;
                r_tlast    <= inStream_tlast;
                if (w_first) r_sel <= inStream_tdest;
            end else if (r_hold_vld && w_port_rdy) begin
                r_hold_vld <= 1'b0;
            end

            if (w_acc && inStream_tlast) begin
                r_state <= S_IDLE;
            end else if (w_acc && w_first) begin
                r_state <= w_dest_bad ? S_DROP : S_FWD;
            end

            if (w_new_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    always_comb begin
        outStream_tvalid = '0;
        for (int p = 0; p < NUM_OUT; p++) begin
            outStream_tvalid[p] = r_hold_vld && (r_sel == 3'(p));
        end
    end

    assign outStream_tdata = r_tdata;
    assign outStream_tdest = r_tdest;
    assign outStream_tid   = r_tid;
    assign outStream_tlast = r_tlast;
    assign drop_count      = r_drop_count;
    assign busy            = (r_state != S_IDLE) || r_hold_vld;

endmodule
